// File: rtl/circ_buf_ctrl_if.sv
// Handshake and pointer bundle shared by circ_buf_ctrl and the producer/consumer
// side that drives requests and watches the decoder/mux controls.
interface circ_buf_ctrl_if #(
  parameter int SIZE = 8
) ();
  localparam int PW = $clog2(SIZE);
  localparam int CW = $clog2(SIZE + 1);

  logic          clear;
  logic          wr_req;
  logic          wr_ready;
  logic          wr_en;
  logic [PW-1:0] wr_ptr;
  logic          rd_req;
  logic          rd_valid;
  logic          rd_fire;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport master (
    output clear, wr_req, rd_req,
    input  wr_ready, wr_en, wr_ptr, rd_valid, rd_fire, rd_ptr, count, full, empty
  );

  modport slave (
    input  clear, wr_req, rd_req,
    output wr_ready, wr_en, wr_ptr, rd_valid, rd_fire, rd_ptr, count, full, empty
  );
endinterface

// File: rtl/circ_buf_ctrl.sv
// Pointer/occupancy controller for a circular register buffer: WRITE_SIZE entries
// per accepted write, READ_SIZE per accepted read, with a synchronous flush.
module circ_buf_ctrl #(
  parameter int SIZE       = 8,
  parameter int WRITE_SIZE = 2,
  parameter int READ_SIZE  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  circ_buf_ctrl_if.slave bus
);
  localparam int PW = $clog2(SIZE);
  localparam int CW = $clog2(SIZE + 1);

  localparam logic [PW:0]   WR_STEP  = (PW+1)'(WRITE_SIZE);
  localparam logic [PW:0]   RD_STEP  = (PW+1)'(READ_SIZE);
  localparam logic [PW:0]   SIZE_P   = (PW+1)'(SIZE);
  localparam logic [CW-1:0] WR_CNT   = CW'(WRITE_SIZE);
  localparam logic [CW-1:0] RD_CNT   = CW'(READ_SIZE);
  localparam logic [CW-1:0] SIZE_C   = CW'(SIZE);
  localparam logic [CW-1:0] WR_LIMIT = CW'(SIZE - WRITE_SIZE);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW:0]   wr_sum, rd_sum;
  logic [PW-1:0] wr_ptr_adv, rd_ptr_adv;
  logic          wr_ready, rd_valid, wr_en, rd_fire;

  // Room is judged on the registered count only, so a same-cycle read never frees space.
  always_comb begin
    wr_ready = (count_q <= WR_LIMIT);
    rd_valid = (count_q >= RD_CNT);
    wr_en    = bus.wr_req & wr_ready & ~bus.clear;
    rd_fire  = bus.rd_req & rd_valid & ~bus.clear;
  end

  // Exact modulo for any SIZE: one extra bit, then a single conditional subtract.
  always_comb begin
    wr_sum     = {1'b0, wr_ptr_q} + WR_STEP;
    rd_sum     = {1'b0, rd_ptr_q} + RD_STEP;
    wr_ptr_adv = (wr_sum >= SIZE_P) ? PW'(wr_sum - SIZE_P) : wr_sum[PW-1:0];
    rd_ptr_adv = (rd_sum >= SIZE_P) ? PW'(rd_sum - SIZE_P) : rd_sum[PW-1:0];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_adv;
      end
      if (rd_fire) begin
        rd_ptr_d = rd_ptr_adv;
      end
      count_d = count_q + (wr_en ? WR_CNT : '0) - (rd_fire ? RD_CNT : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.rd_valid = rd_valid;
  assign bus.wr_en    = wr_en;
  assign bus.rd_fire  = rd_fire;
  assign bus.wr_ptr   = wr_ptr_q;
  assign bus.rd_ptr   = rd_ptr_q;
  assign bus.count    = count_q;
  assign bus.full     = (count_q == SIZE_C);
  assign bus.empty    = (count_q == '0);

  // Pointer distance must equal occupancy except when full (pointers coincide then too).
  logic [CW-1:0] ptr_span;
  always_comb begin
    ptr_span = (wr_ptr_q >= rd_ptr_q) ? CW'(wr_ptr_q - rd_ptr_q)
                                      : CW'(SIZE_C + CW'(wr_ptr_q) - CW'(rd_ptr_q));
  end

  a_span_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
    (count_q != SIZE_C) |-> (count_q == ptr_span));
  a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= SIZE_C);
endmodule

// File: tb/tb_circ_buf_ctrl.sv
// Scoreboard bench for circ_buf_ctrl: default instance (8/2/1) and a
// non-power-of-two instance (6/4/4) driven from one sequence of scenario tasks.
module tb_circ_buf_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  circ_buf_ctrl_if #(.SIZE(8)) bus_a ();
  circ_buf_ctrl_if #(.SIZE(6)) bus_b ();

  circ_buf_ctrl #(.SIZE(8), .WRITE_SIZE(2), .READ_SIZE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  circ_buf_ctrl #(.SIZE(6), .WRITE_SIZE(4), .READ_SIZE(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // vec layout: [15]wr_en [14]rd_fire [13]wr_ready [12]rd_valid [11]full [10]empty
  //             [9:7]wr_ptr [6:4]rd_ptr [3:0]count
  typedef struct {
    int          id;
    string       tag;
    logic [15:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_wp [2];
  int   m_rp [2];
  int   m_cnt[2];

  function automatic int sz(input int id); return (id == 0) ? 8 : 6; endfunction
  function automatic int ws(input int id); return (id == 0) ? 2 : 4; endfunction
  function automatic int rs(input int id); return (id == 0) ? 1 : 4; endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wp[i] = 0; m_rp[i] = 0; m_cnt[i] = 0;
    end
  endfunction

  function automatic logic [15:0] model_vec(input int id, input logic c, input logic w, input logic r);
    logic rdy, vld;
    rdy = (m_cnt[id] <= sz(id) - ws(id));
    vld = (m_cnt[id] >= rs(id));
    return {w & rdy & ~c, r & vld & ~c, rdy, vld, m_cnt[id] == sz(id), m_cnt[id] == 0,
            3'(m_wp[id]), 3'(m_rp[id]), 4'(m_cnt[id])};
  endfunction

  function automatic void model_update(input int id, input logic c, input logic w, input logic r);
    logic we, rf;
    we = w && (m_cnt[id] <= sz(id) - ws(id)) && !c;
    rf = r && (m_cnt[id] >= rs(id)) && !c;
    if (c) begin
      m_wp[id] = 0; m_rp[id] = 0; m_cnt[id] = 0;
    end else begin
      if (we) begin m_wp[id] = (m_wp[id] + ws(id)) % sz(id); m_cnt[id] += ws(id); end
      if (rf) begin m_rp[id] = (m_rp[id] + rs(id)) % sz(id); m_cnt[id] -= rs(id); end
    end
  endfunction

  function automatic logic [15:0] observe(input int id);
    if (id == 0)
      return {bus_a.wr_en, bus_a.rd_fire, bus_a.wr_ready, bus_a.rd_valid, bus_a.full,
              bus_a.empty, bus_a.wr_ptr, bus_a.rd_ptr, bus_a.count};
    return {bus_b.wr_en, bus_b.rd_fire, bus_b.wr_ready, bus_b.rd_valid, bus_b.full,
            bus_b.empty, bus_b.wr_ptr, bus_b.rd_ptr, 1'b0, bus_b.count};
  endfunction

  task automatic set_inputs(input int id, input logic c, input logic w, input logic r);
    bus_a.clear = (id == 0) ? c : 1'b0;
    bus_a.wr_req = (id == 0) ? w : 1'b0;
    bus_a.rd_req = (id == 0) ? r : 1'b0;
    bus_b.clear = (id == 1) ? c : 1'b0;
    bus_b.wr_req = (id == 1) ? w : 1'b0;
    bus_b.rd_req = (id == 1) ? r : 1'b0;
  endtask

  // One clock of stimulus: called just after a falling edge, returns just after the next one.
  task automatic step(input int id, input logic c, input logic w, input logic r,
                      input string tag, output logic [15:0] obs);
    exp_t e;
    set_inputs(id, c, w, r);
    exp_q.push_back('{id: id, tag: tag, vec: model_vec(id, c, w, r)});
    #1;
    e   = exp_q.pop_front();
    obs = observe(e.id);
    vectors++;
    $display("[%0t] %s dut%0d clr=%b wr=%b rd=%b obs=%b", $time, e.tag, e.id, c, w, r, obs);
    if (obs !== e.vec) begin
      miscompares++;
      $display("FAIL %s: got %b want %b (we rf rdy vld full empty wp rp cnt)", e.tag, obs, e.vec);
    end
    model_update(id, c, w, r);
    @(negedge clk);
    set_inputs(id, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [15:0] o;
    exp_t        e;
    set_inputs(0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    vectors++;
    if (observe(0) !== 16'b0010_0100_0000_0000) begin
      miscompares++;
      $display("FAIL reset_initial: got %b want %b", observe(0), 16'b0010_0100_0000_0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 1'b0, "reset_pre_wr", o);
    vectors++;
    if (bus_a.count !== 4'd6 || bus_a.wr_ptr !== 3'd6) begin
      miscompares++;
      $display("FAIL reset_pre_state: got count=%0d wr_ptr=%0d want count=6 wr_ptr=6", bus_a.count, bus_a.wr_ptr);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    exp_q.push_back('{id: 0, tag: "reset_async", vec: model_vec(0, 1'b0, 1'b0, 1'b0)});
    #1;
    e = exp_q.pop_front();
    vectors++;
    if (observe(e.id) !== e.vec) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", e.tag, observe(e.id), e.vec);
    end
    vectors++;
    if ({bus_a.wr_ptr, bus_a.rd_ptr, bus_a.count, bus_a.empty, bus_a.wr_ready, bus_a.rd_valid} !== 13'b000_000_0000_110) begin
      miscompares++;
      $display("FAIL reset_async_fields: got wp=%0d rp=%0d cnt=%0d empty=%b rdy=%b vld=%b want 0 0 0 1 1 0",
               bus_a.wr_ptr, bus_a.rd_ptr, bus_a.count, bus_a.empty, bus_a.wr_ready, bus_a.rd_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [15:0] o;
    logic [3:0]  cnt_seq [5] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd8};
    logic [2:0]  wp_seq  [5] = '{3'd2, 3'd4, 3'd6, 3'd0, 3'd0};
    logic        en_seq  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b0, 1'b1, 1'b0, "fill", o);
      vectors++;
      if (o[15] !== en_seq[i] || bus_a.count !== cnt_seq[i] || bus_a.wr_ptr !== wp_seq[i]) begin
        miscompares++;
        $display("FAIL fill_%0d: got en=%b cnt=%0d wp=%0d want en=%b cnt=%0d wp=%0d", i,
                 o[15], bus_a.count, bus_a.wr_ptr, en_seq[i], cnt_seq[i], wp_seq[i]);
      end
    end
    vectors++;
    if (bus_a.full !== 1'b1 || bus_a.wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: got full=%b rdy=%b want full=1 rdy=0", bus_a.full, bus_a.wr_ready);
    end
  endtask

  task automatic test_threshold();
    logic [15:0] o;
    step(0, 1'b0, 1'b0, 1'b1, "thr_rd1", o);
    vectors++;
    if (bus_a.count !== 4'd7 || bus_a.rd_ptr !== 3'd1 || bus_a.wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL thr_rd1: got cnt=%0d rp=%0d rdy=%b want 7 1 0", bus_a.count, bus_a.rd_ptr, bus_a.wr_ready);
    end
    step(0, 1'b0, 1'b0, 1'b1, "thr_rd2", o);
    vectors++;
    if (bus_a.count !== 4'd6 || bus_a.wr_ready !== 1'b1 || bus_a.wr_ptr !== 3'd0) begin
      miscompares++;
      $display("FAIL thr_rd2: got cnt=%0d rdy=%b wp=%0d want 6 1 0", bus_a.count, bus_a.wr_ready, bus_a.wr_ptr);
    end
    step(0, 1'b0, 1'b1, 1'b0, "thr_wr", o);
    vectors++;
    if (o[15] !== 1'b1 || bus_a.wr_ptr !== 3'd2 || bus_a.count !== 4'd8) begin
      miscompares++;
      $display("FAIL thr_wr: got en=%b wp=%0d cnt=%0d want 1 2 8", o[15], bus_a.wr_ptr, bus_a.count);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] o;
    step(1, 1'b0, 1'b1, 1'b0, "wrap_wr0", o);
    step(1, 1'b0, 1'b0, 1'b1, "wrap_rd", o);
    vectors++;
    if (bus_b.count !== 3'd0 || bus_b.rd_ptr !== 3'd4 || bus_b.wr_ptr !== 3'd4) begin
      miscompares++;
      $display("FAIL wrap_rd: got cnt=%0d rp=%0d wp=%0d want 0 4 4", bus_b.count, bus_b.rd_ptr, bus_b.wr_ptr);
    end
    step(1, 1'b0, 1'b1, 1'b0, "wrap_wr4", o);
    vectors++;
    if (o[15] !== 1'b1 || bus_b.wr_ptr !== 3'd2 || bus_b.count !== 3'd4) begin
      miscompares++;
      $display("FAIL wrap_wr4: got en=%b wp=%0d cnt=%0d want 1 2 4", o[15], bus_b.wr_ptr, bus_b.count);
    end
  endtask

  task automatic test_concurrent();
    logic [15:0] o;
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 1'b1, "conc_drain", o);
    step(0, 1'b0, 1'b1, 1'b1, "conc_both", o);
    vectors++;
    if (o[15:14] !== 2'b11 || bus_a.count !== 4'd6 || bus_a.wr_ptr !== 3'd4 || bus_a.rd_ptr !== 3'd6) begin
      miscompares++;
      $display("FAIL conc_both: got en/fire=%b cnt=%0d wp=%0d rp=%0d want 11 6 4 6",
               o[15:14], bus_a.count, bus_a.wr_ptr, bus_a.rd_ptr);
    end
    step(0, 1'b0, 1'b1, 1'b0, "conc_fill", o);
    step(0, 1'b0, 1'b0, 1'b1, "conc_to7", o);
    step(0, 1'b0, 1'b1, 1'b1, "conc_rd_only", o);
    vectors++;
    if (o[15:14] !== 2'b01 || bus_a.count !== 4'd6 || bus_a.wr_ptr !== 3'd6 || bus_a.rd_ptr !== 3'd0) begin
      miscompares++;
      $display("FAIL conc_rd_only: got en/fire=%b cnt=%0d wp=%0d rp=%0d want 01 6 6 0",
               o[15:14], bus_a.count, bus_a.wr_ptr, bus_a.rd_ptr);
    end
  endtask

  task automatic test_clear();
    logic [15:0] o;
    step(0, 1'b0, 1'b0, 1'b1, "clr_drain", o);
    step(0, 1'b0, 1'b0, 1'b1, "clr_drain", o);
    step(0, 1'b1, 1'b1, 1'b1, "clr_all", o);
    vectors++;
    if (o[15:14] !== 2'b00 || o[3:0] !== 4'd4 || bus_a.count !== 4'd0 || bus_a.wr_ptr !== 3'd0 ||
        bus_a.rd_ptr !== 3'd0 || bus_a.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_all: got en/fire=%b pre_cnt=%0d cnt=%0d wp=%0d rp=%0d empty=%b want 00 4 0 0 0 1",
               o[15:14], o[3:0], bus_a.count, bus_a.wr_ptr, bus_a.rd_ptr, bus_a.empty);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] o;
    for (int i = 0; i < 70; i++) begin
      int id;
      id = (i < 40) ? 0 : 1;
      step(id, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           "b2b_random", o);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_threshold();
    test_wrap();
    test_concurrent();
    test_clear();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
